// File: rtl/alu_pkg.sv
// Shared encodings for the accumulator: opcodes, FSM states and flag bit positions.
`default_nettype none

package alu_pkg;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_RESP = 2'b10
   } state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/addsub_flags.sv
// Combinational LOAD/ADD/SUB/CLR datapath producing the next accumulator value and {N,Z,C,V}.
// Optional SATURATE_EN clamps overflowing ADD/SUB results instead of wrapping.
`default_nettype none

module addsub_flags
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] b_neg,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] res,
   output logic [3:0]       flags
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] raw;
   logic             carry;
   logic             ovf;

   always_comb begin
      sum   = '0;
      raw   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (op)
         OP_LOAD: raw = b;
         OP_ADD: begin
            sum   = {1'b0, acc} + {1'b0, b};
            raw   = sum[WIDTH-1:0];
            carry = sum[WIDTH];
            ovf   = (acc[MSB] == b[MSB]) && (raw[MSB] != acc[MSB]);
         end
         OP_SUB: begin
            sum   = {1'b0, acc} + {1'b0, b_neg};
            raw   = sum[WIDTH-1:0];
            carry = (acc < b);
            // Overflow judged against b itself so the most-negative operand is handled.
            ovf   = (acc[MSB] != b[MSB]) && (raw[MSB] != acc[MSB]);
         end
         default: raw = '0;
      endcase
   end

   always_comb begin
      res = raw;
`ifdef SATURATE_EN
      // On overflow the true result has the sign of acc, so clamp toward it.
      if (ovf) begin
         res = acc[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
      flags         = '0;
      flags[FLAG_N] = res[MSB];
      flags[FLAG_Z] = (res == '0);
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
   end

endmodule

`default_nettype wire

// File: rtl/four_bit_accumulator.sv
// Handshaked add/subtract accumulator: IDLE -> CALC -> RESP FSM, operand latch and result/flag registers.
// Build option: SATURATE_EN (clamp on signed overflow, handled in addsub_flags).
`default_nettype none

module four_bit_accumulator
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] b_neg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] b_neg_q, b_neg_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [3:0]       flags_q, flags_d;
   logic             out_valid_q, out_valid_d;

   logic [WIDTH-1:0] alu_res;
   logic [3:0]       alu_flags;

   addsub_flags #(.WIDTH(WIDTH)) u_addsub_flags (
      .acc   (acc_q),
      .b     (b_q),
      .b_neg (b_neg_q),
      .op    (op_q),
      .res   (alu_res),
      .flags (alu_flags)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      b_d         = b_q;
      b_neg_d     = b_neg_q;
      acc_d       = acc_q;
      flags_d     = flags_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = op;
               b_d     = b;
               b_neg_d = b_neg;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            acc_d   = alu_res;
            flags_d = alu_flags;
            state_d = S_RESP;
         end
         S_RESP: begin
            // out_valid is registered, so it rises one edge after entering RESP.
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= OP_LOAD;
         b_q         <= '0;
         b_neg_q     <= '0;
         acc_q       <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         b_q         <= b_d;
         b_neg_q     <= b_neg_d;
         acc_q       <= acc_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign result    = acc_q;
   assign flags     = flags_q;

endmodule

`default_nettype wire
